// File: rtl/seg_tube_scan_driver_pkg.sv
// Shared constants for the 8-digit scan driver: nibble codes, segment patterns and phase values.
// Segment patterns are laid out {dp,g,f,e,d,c,b,a}, active-high.
package seg_tube_scan_driver_pkg;

  typedef logic [1:0] phase_t;
  typedef logic [7:0] seg_pat_t;

  localparam phase_t PHASE_0 = 2'd0;
  localparam phase_t PHASE_1 = 2'd1;
  localparam phase_t PHASE_2 = 2'd2;
  localparam phase_t PHASE_3 = 2'd3;

  localparam logic [3:0] SEG_CODE_DASH  = 4'hC;
  localparam logic [3:0] SEG_CODE_BLANK = 4'hF;

  localparam seg_pat_t SEG_PAT_0     = 8'h3F;
  localparam seg_pat_t SEG_PAT_1     = 8'h06;
  localparam seg_pat_t SEG_PAT_2     = 8'h5B;
  localparam seg_pat_t SEG_PAT_3     = 8'h4F;
  localparam seg_pat_t SEG_PAT_4     = 8'h66;
  localparam seg_pat_t SEG_PAT_5     = 8'h6D;
  localparam seg_pat_t SEG_PAT_6     = 8'h7D;
  localparam seg_pat_t SEG_PAT_7     = 8'h07;
  localparam seg_pat_t SEG_PAT_8     = 8'h7F;
  localparam seg_pat_t SEG_PAT_9     = 8'h6F;
  localparam seg_pat_t SEG_PAT_A     = 8'h77;
  localparam seg_pat_t SEG_PAT_B     = 8'h7C;
  localparam seg_pat_t SEG_PAT_D     = 8'h5E;
  localparam seg_pat_t SEG_PAT_E     = 8'h79;
  localparam seg_pat_t SEG_PAT_DASH  = 8'h40;
  localparam seg_pat_t SEG_PAT_BLANK = 8'h00;

endpackage

// File: rtl/seg_tube_scan_driver_if.sv
// Display word in, tube select and segment buses out. blink_mask exists only with SEG_BLINK_EN.
interface seg_tube_scan_driver_if;

  logic [31:0] numbers;
`ifdef SEG_BLINK_EN
  logic [7:0]  blink_mask;
`endif
  logic [7:0]  tube_sel;
  logic [7:0]  seg_right;
  logic [7:0]  seg_left;

`ifdef SEG_BLINK_EN
  modport master (output numbers, output blink_mask,
                  input tube_sel, input seg_right, input seg_left);
  modport slave  (input numbers, input blink_mask,
                  output tube_sel, output seg_right, output seg_left);
`else
  modport master (output numbers, input tube_sel, input seg_right, input seg_left);
  modport slave  (input numbers, output tube_sel, output seg_right, output seg_left);
`endif

endinterface

// File: rtl/seg_tube_scan_driver_seg7_decode.sv
// Combinational nibble-to-segment decoder; C shows a dash and F blanks the digit.
module seg7_decode
  import seg_tube_scan_driver_pkg::*;
(
  input  logic [3:0] i_code,
  output seg_pat_t   o_pat
);

  always_comb begin
    o_pat = SEG_PAT_BLANK;
    unique case (i_code)
      4'h0:           o_pat = SEG_PAT_0;
      4'h1:           o_pat = SEG_PAT_1;
      4'h2:           o_pat = SEG_PAT_2;
      4'h3:           o_pat = SEG_PAT_3;
      4'h4:           o_pat = SEG_PAT_4;
      4'h5:           o_pat = SEG_PAT_5;
      4'h6:           o_pat = SEG_PAT_6;
      4'h7:           o_pat = SEG_PAT_7;
      4'h8:           o_pat = SEG_PAT_8;
      4'h9:           o_pat = SEG_PAT_9;
      4'hA:           o_pat = SEG_PAT_A;
      4'hB:           o_pat = SEG_PAT_B;
      SEG_CODE_DASH:  o_pat = SEG_PAT_DASH;
      4'hD:           o_pat = SEG_PAT_D;
      4'hE:           o_pat = SEG_PAT_E;
      SEG_CODE_BLANK: o_pat = SEG_PAT_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_tube_scan_driver.sv
// 4-phase scan driver for two 4-digit 7-segment banks with per-frame snapshot and blanking gap.
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.
module seg_tube_scan_driver
  import seg_tube_scan_driver_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned BLINK_HZ    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  seg_tube_scan_driver_if.slave io_bus
);

  localparam int unsigned Div  = CLK_FREQ_HZ / SCAN_HZ;
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

  if (Div < BLANK_CYC + 1) begin : gen_bad_div
    $fatal(1, "seg_tube_scan_driver: DIV must exceed BLANK_CYC");
  end
  if (BLINK_HZ == 0) begin : gen_bad_blink
    $fatal(1, "seg_tube_scan_driver: BLINK_HZ must be non-zero");
  end

  logic [DivW-1:0] r_div_cnt, w_div_cnt_nxt;
  phase_t          r_phase, w_phase_nxt;
  logic [31:0]     r_shadow, w_shadow_nxt;
  logic            w_tick;
  logic            w_blank;
  logic [3:0]      w_code_right, w_code_left;
  seg_pat_t        w_pat_right, w_pat_left;
  logic            w_mute_right, w_mute_left;
  logic [7:0]      w_sel_nxt;
  logic [7:0]      r_tube_sel, r_seg_right, r_seg_left;

  // Outputs are built from next-state values so the registered outputs line up with div_cnt.
  always_comb begin
    w_tick        = (r_div_cnt == DivW'(Div - 1));
    w_div_cnt_nxt = w_tick ? '0 : r_div_cnt + 1'b1;
    w_phase_nxt   = w_tick ? r_phase + 2'd1 : r_phase;
    w_shadow_nxt  = (w_tick && r_phase == PHASE_3) ? io_bus.numbers : r_shadow;
    w_blank       = (32'(w_div_cnt_nxt) < BLANK_CYC);
    w_code_right  = w_shadow_nxt[{1'b0, w_phase_nxt, 2'b00} +: 4];
    w_code_left   = w_shadow_nxt[{1'b1, w_phase_nxt, 2'b00} +: 4];
    w_sel_nxt     = 8'h00;
    w_sel_nxt[{1'b0, w_phase_nxt}] = 1'b1;
    w_sel_nxt[{1'b1, w_phase_nxt}] = 1'b1;
  end

  seg7_decode u_dec_right (
    .i_code (w_code_right),
    .o_pat  (w_pat_right)
  );

  seg7_decode u_dec_left (
    .i_code (w_code_left),
    .o_pat  (w_pat_left)
  );

`ifdef SEG_BLINK_EN
  localparam int unsigned BlinkDiv  = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int unsigned BlinkW    = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;

  logic [BlinkW-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic              r_blink_on, w_blink_on_nxt;
  logic              w_blink_wrap;

  always_comb begin
    w_blink_wrap    = (r_blink_cnt == BlinkW'(BlinkDiv - 1));
    w_blink_cnt_nxt = w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
    w_blink_on_nxt  = w_blink_wrap ? ~r_blink_on : r_blink_on;
    // Mask is sampled live so blinking can start or stop mid-frame.
    w_mute_right    = ~w_blink_on_nxt & io_bus.blink_mask[{1'b0, w_phase_nxt}];
    w_mute_left     = ~w_blink_on_nxt & io_bus.blink_mask[{1'b1, w_phase_nxt}];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
    end
  end
`else
  assign w_mute_right = 1'b0;
  assign w_mute_left  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_div_cnt   <= '0;
      r_phase     <= PHASE_0;
      r_shadow    <= 32'hFFFF_FFFF;
      r_tube_sel  <= 8'h00;
      r_seg_right <= 8'h00;
      r_seg_left  <= 8'h00;
    end else begin
      r_div_cnt   <= w_div_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_shadow    <= w_shadow_nxt;
      r_tube_sel  <= w_blank ? 8'h00 : w_sel_nxt;
      r_seg_right <= (w_blank || w_mute_right) ? 8'h00 : w_pat_right;
      r_seg_left  <= (w_blank || w_mute_left)  ? 8'h00 : w_pat_left;
    end
  end

  assign io_bus.tube_sel  = r_tube_sel;
  assign io_bus.seg_right = r_seg_right;
  assign io_bus.seg_left  = r_seg_left;

endmodule

// File: tb/tb_seg_tube_scan_driver.sv
// Scoreboard bench: stimulus pushes expected outputs from a time-based display model,
// a monitor pops and compares one entry per clock.
module tb_seg_tube_scan_driver;

  localparam int unsigned ClkHz    = 16;
  localparam int unsigned ScanHz   = 2;
  localparam int unsigned BlankCyc = 2;
  localparam int unsigned BlinkHz  = 1;
  localparam int unsigned Div      = ClkHz / ScanHz;
  localparam int unsigned Frame    = 4 * Div;
  localparam int unsigned BlinkDiv = ClkHz / (2 * BlinkHz);
`ifdef SEG_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  typedef struct {
    int unsigned t;
    logic [7:0]  sel;
    logic [7:0]  right;
    logic [7:0]  left;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  seg_tube_scan_driver_if bus ();

  seg_tube_scan_driver #(
    .CLK_FREQ_HZ (ClkHz),
    .SCAN_HZ     (ScanHz),
    .BLANK_CYC   (BlankCyc),
    .BLINK_HZ    (BlinkHz)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned t     = 0;
  logic [31:0] sh    = 32'hFFFF_FFFF;
  logic [7:0]  mask  = 8'h00;
  logic [7:0]  dec_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h40, 8'h5E, 8'h79, 8'h00};

  // t counts cycles since reset; the display is a pure function of t, the latched word and mask.
  function automatic exp_t model(int unsigned tt, logic [31:0] s, logic [7:0] m);
    exp_t        e;
    int unsigned p;
    e.t = tt; e.sel = 8'h00; e.right = 8'h00; e.left = 8'h00;
    if ((tt % Div) >= BlankCyc) begin
      p       = (tt / Div) % 4;
      e.sel   = 8'(1 << p) | 8'(1 << (p + 4));
      e.right = dec_tab[s[4*p +: 4]];
      e.left  = dec_tab[s[4*(p+4) +: 4]];
      if (BlinkEn && ((tt / BlinkDiv) % 2) == 1) begin
        if (m[p])     e.right = 8'h00;
        if (m[p + 4]) e.left  = 8'h00;
      end
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic [31:0] n);
    @(negedge clk);
    rstn        = r;
    bus.numbers = n;
`ifdef SEG_BLINK_EN
    bus.blink_mask = mask;
`endif
    if (!r) begin
      t  = 0;
      sh = 32'hFFFF_FFFF;
    end else begin
      t = t + 1;
      if ((t % Frame) == 0) sh = n;
    end
    q.push_back(model(t, sh, mask));
  endtask

  task automatic chk(input string name, input int unsigned tt, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %02h expected %02h", name, tt, act, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("tube_sel", e.t, bus.tube_sel, e.sel);
      chk("seg_right", e.t, bus.seg_right, e.right);
      chk("seg_left", e.t, bus.seg_left, e.left);
    end
  end

  initial begin
    logic [31:0] nums;
    bus.numbers = 32'h12C3_4C56;
`ifdef SEG_BLINK_EN
    bus.blink_mask = 8'h00;
`endif
    nums = 32'h12C3_4C56;
    repeat (2) step(1'b0, nums);
    repeat (100) step(1'b1, nums);

    // Word change in mid-phase 1 must wait for the next frame wrap.
    while ((t % Frame) != Div + 4) step(1'b1, nums);
    nums = 32'hFFFF_FFFF;
    repeat (70) step(1'b1, nums);

    // One-cycle reset pulse in mid-phase 2.
    nums = 32'h8765_4321;
    while ((t % Frame) != 2 * Div + 4) step(1'b1, nums);
    step(1'b0, nums);
    repeat (70) step(1'b1, nums);

    nums = 32'h0123_4567;
    repeat (70) step(1'b1, nums);
    nums = 32'h89AB_CDEF;
    repeat (70) step(1'b1, nums);

    mask = 8'h03;
    repeat (70) step(1'b1, nums);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) nums = $urandom;
      if ($urandom_range(19) == 0) mask = 8'($urandom);
      step(($urandom_range(149) == 0) ? 1'b0 : 1'b1, nums);
    end

    @(posedge clk);
    #3;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
